mmio_timer_core: RTL and testbench

//  Slot-side MMIO timer device (slot 0 of the MMIO map, base 0x4600_0000). Answers the slot

---
 rtl/const_pkg.sv | 27 ++
 rtl/mmio_slot_responder.sv | 95 +++++++++
 rtl/mmio_timer_core.sv | 152 +++++++++++++++
 tb/tb_mmio_timer_core.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/const_pkg.sv
// Shared MMIO constants: timer register offsets, CTRL bit positions,
// and the slot responder state encoding.
package const_pkg;

    localparam logic [7:0] TMR_CTRL     = 8'h00;
    localparam logic [7:0] TMR_LOAD     = 8'h01;
    localparam logic [7:0] TMR_COUNT    = 8'h02;
    localparam logic [7:0] TMR_STATUS   = 8'h03;
    localparam logic [7:0] TMR_PRESCALE = 8'h04;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IRQ  = 2;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_EXEC,
        SLOT_RESP
    } slot_state_e;

    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } tmr_ctrl_t;

endpackage

// File: rtl/mmio_slot_responder.sv
// Generic MMIO slot FSM: accepts a request, runs one register access,
// then holds done/error/rd_data until the controller finishes.
module mmio_slot_responder
    import const_pkg::*;
(
    input  logic        aclk,
    input  logic        arst_n,
    input  logic        chip_select_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [7:0]  reg_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic        transaction_completed_i,
    output logic [31:0] rd_data_o,
    output logic        wr_done_o,
    output logic        rd_done_o,
    output logic        idle_o,
    output logic        slave_error_o,
    output logic        decode_error_o,
    output logic        signal_received_o,
    output logic        reg_wr_o,
    output logic        reg_rd_o,
    output logic [7:0]  addr_o,
    output logic [31:0] wdata_o,
    input  logic [31:0] rdata_i,
    input  logic        slv_err_i,
    input  logic        dec_err_i
);

    slot_state_e state_q;
    logic [7:0]  addr_q;
    logic        op_wr_q;
    logic [31:0] rd_data_q;
    logic        wr_done_q;
    logic        rd_done_q;
    logic        slv_q;
    logic        dec_q;
    logic        accept;

    assign accept = (state_q == SLOT_IDLE) & chip_select_i
                  & (read_i | write_i);

    assign idle_o            = (state_q == SLOT_IDLE);
    assign signal_received_o = accept;
    assign reg_wr_o          = (state_q == SLOT_EXEC) & op_wr_q;
    assign reg_rd_o          = (state_q == SLOT_EXEC) & ~op_wr_q;
    assign addr_o            = addr_q;
    assign wdata_o           = wr_data_i;
    assign rd_data_o         = rd_data_q;
    assign wr_done_o         = wr_done_q;
    assign rd_done_o         = rd_done_q;
    assign slave_error_o     = slv_q;
    assign decode_error_o    = dec_q;

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= SLOT_IDLE;
            addr_q    <= '0;
            op_wr_q   <= 1'b0;
            rd_data_q <= '0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            slv_q     <= 1'b0;
            dec_q     <= 1'b0;
        end else begin
            unique case (state_q)
                SLOT_IDLE: begin
                    if (accept) begin
                        addr_q  <= reg_addr_i;
                        op_wr_q <= write_i;
                        state_q <= SLOT_EXEC;
                    end
                end
                SLOT_EXEC: begin
                    // Result flags persist past RESP for late sampling
                    rd_data_q <= op_wr_q ? 32'd0 : rdata_i;
                    slv_q     <= slv_err_i;
                    dec_q     <= dec_err_i;
                    wr_done_q <= op_wr_q;
                    rd_done_q <= ~op_wr_q;
                    state_q   <= SLOT_RESP;
                end
                SLOT_RESP: begin
                    if (transaction_completed_i) begin
                        wr_done_q <= 1'b0;
                        rd_done_q <= 1'b0;
                        state_q   <= SLOT_IDLE;
                    end
                end
                default: state_q <= SLOT_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mmio_timer_core.sv
// MMIO timer: prescaled down-counter with one-shot/auto-reload modes
// and a level interrupt, behind the shared slot responder.
module mmio_timer_core
    import const_pkg::*;
#(
    parameter int PRESCALE_W = 16,
    parameter int COUNT_W    = 32
) (
    input  logic        aclk,
    input  logic        arst_n,
    input  logic        chip_select,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  reg_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        wr_done,
    output logic        rd_done,
    output logic        idle,
    output logic        slave_error,
    output logic        decode_error,
    output logic        signal_received,
    input  logic        transaction_completed,
    output logic        irq
);

    logic        reg_wr;
    logic        reg_rd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mapped;
    logic        slv_err;
    logic        dec_err;

    tmr_ctrl_t             ctrl_q, ctrl_d;
    logic [COUNT_W-1:0]    load_q, load_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic                  status_q, status_d;
    logic [PRESCALE_W-1:0] psc_q, psc_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                  tick;
    logic                  exp_set;
    logic                  exp_clr;

    mmio_slot_responder u_slot (
        .aclk                    (aclk),
        .arst_n                  (arst_n),
        .chip_select_i           (chip_select),
        .read_i                  (read),
        .write_i                 (write),
        .reg_addr_i              (reg_addr),
        .wr_data_i               (wr_data),
        .transaction_completed_i (transaction_completed),
        .rd_data_o               (rd_data),
        .wr_done_o               (wr_done),
        .rd_done_o               (rd_done),
        .idle_o                  (idle),
        .slave_error_o           (slave_error),
        .decode_error_o          (decode_error),
        .signal_received_o       (signal_received),
        .reg_wr_o                (reg_wr),
        .reg_rd_o                (reg_rd),
        .addr_o                  (addr),
        .wdata_o                 (wdata),
        .rdata_i                 (rdata),
        .slv_err_i               (slv_err),
        .dec_err_i               (dec_err)
    );

    always_comb begin
        rdata  = 32'd0;
        mapped = 1'b1;
        case (addr)
            TMR_CTRL:     rdata = {29'd0, ctrl_q};
            TMR_LOAD:     rdata = 32'(load_q);
            TMR_COUNT:    rdata = 32'(count_q);
            TMR_STATUS:   rdata = {31'd0, status_q};
            TMR_PRESCALE: rdata = 32'(psc_q);
            default:      mapped = 1'b0;
        endcase
    end

    assign dec_err = (reg_wr | reg_rd) & ~mapped;
    assign slv_err = reg_wr & (addr == TMR_COUNT);
    assign tick    = ctrl_q.en & (pcnt_q == psc_q);
    assign irq     = status_q & ctrl_q.irq_en;

    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        psc_d   = psc_q;
        pcnt_d  = pcnt_q;
        exp_set = 1'b0;
        exp_clr = 1'b0;

        if (ctrl_q.en) begin
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        end
        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else begin
                exp_set = 1'b1;
                if (ctrl_q.auto_reload) begin
                    count_d = load_q;
                end else begin
                    ctrl_d.en = 1'b0;
                end
            end
        end

        // Bus writes take priority over the hardware update of CTRL
        if (reg_wr) begin
            case (addr)
                TMR_CTRL: begin
                    ctrl_d = wdata[2:0];
                    if (!ctrl_q.en && wdata[CTRL_EN]) begin
                        count_d = load_q;
                        pcnt_d  = '0;
                    end
                end
                TMR_LOAD:     load_d  = wdata[COUNT_W-1:0];
                TMR_STATUS:   exp_clr = wdata[0];
                TMR_PRESCALE: psc_d   = wdata[PRESCALE_W-1:0];
                default: ;
            endcase
        end

        status_d = exp_set | (status_q & ~exp_clr);
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            ctrl_q   <= '0;
            load_q   <= '0;
            count_q  <= '0;
            status_q <= 1'b0;
            psc_q    <= '0;
            pcnt_q   <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            load_q   <= load_d;
            count_q  <= count_d;
            status_q <= status_d;
            psc_q    <= psc_d;
            pcnt_q   <= pcnt_d;
        end
    end

endmodule

// File: tb/tb_mmio_timer_core.sv
// Directed bench for mmio_timer_core: register map, counter modes,
// slot handshake timing, errors and reset abort.
module tb_mmio_timer_core;
    import const_pkg::*;

    logic        aclk = 1'b0;
    logic        arst_n = 1'b0;
    logic        cs = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  addr = 8'd0;
    logic [31:0] wdata = 32'd0;
    logic        tc = 1'b0;
    logic [31:0] rd_data;
    logic        wr_done, rd_done, idle;
    logic        slave_error, decode_error;
    logic        signal_received, irq;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    logic [31:0] x_rd;
    logic        x_se, x_de, x_wd, x_sr, x_ok;
    int          x_exec;

    mmio_timer_core dut (
        .aclk                  (aclk),
        .arst_n                (arst_n),
        .chip_select           (cs),
        .read                  (rd),
        .write                 (wr),
        .reg_addr              (addr),
        .wr_data               (wdata),
        .rd_data               (rd_data),
        .wr_done               (wr_done),
        .rd_done               (rd_done),
        .idle                  (idle),
        .slave_error           (slave_error),
        .decode_error          (decode_error),
        .signal_received       (signal_received),
        .transaction_completed (tc),
        .irq                   (irq)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after completion
    task automatic xfer(input logic w, input logic [7:0] a,
                        input logic [31:0] d);
        cs = 1'b1; rd = ~w; wr = w; addr = a;
        #1 x_sr = signal_received;
        @(negedge aclk);
        cs = 1'b0; rd = 1'b0; wr = 1'b0; wdata = d;
        x_ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            if (wr_done | rd_done) begin
                x_ok = 1'b1;
                break;
            end
        end
        if (!x_ok) chk("done_timeout", 32'(x_ok), 32'd1);
        x_exec = cyc;
        x_rd = rd_data; x_se = slave_error;
        x_de = decode_error; x_wd = wr_done;
        tc = 1'b1;
        @(negedge aclk);
        tc = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        xfer(1'b1, a, d);
    endtask

    task automatic rd_reg(input string tag, input logic [7:0] a,
                          input logic [31:0] exp);
        xfer(1'b0, a, 32'd0);
        chk(tag, x_rd, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        int x0, e0, t;
        logic held, bad;

        repeat (3) @(negedge aclk);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_flags", 32'({wr_done, rd_done, idle, slave_error,
            decode_error, signal_received, irq}), 32'b0010000);
        arst_n = 1'b1;
        @(negedge aclk);
        rd_reg("rst_ctrl", TMR_CTRL, 32'd0);
        rd_reg("rst_count", TMR_COUNT, 32'd0);

        // One-shot, tick every cycle
        wr_reg(TMR_LOAD, 32'd5);
        wr_reg(TMR_PRESCALE, 32'd0);
        wr_reg(TMR_CTRL, 32'h1);
        repeat (10) @(negedge aclk);
        rd_reg("os_ctrl_en_clr", TMR_CTRL, 32'd0);
        rd_reg("os_status", TMR_STATUS, 32'd1);
        rd_reg("os_count", TMR_COUNT, 32'd0);

        // One-shot, 100-cycle ticks: observe each count value
        wr_reg(TMR_STATUS, 32'h1);
        rd_reg("w1c_clear", TMR_STATUS, 32'd0);
        wr_reg(TMR_PRESCALE, 32'd99);
        wr_reg(TMR_LOAD, 32'd3);
        wr_reg(TMR_CTRL, 32'h1);
        repeat (48) @(negedge aclk);
        rd_reg("cnt3", TMR_COUNT, 32'd3);
        repeat (98) @(negedge aclk);
        rd_reg("cnt2", TMR_COUNT, 32'd2);
        repeat (98) @(negedge aclk);
        rd_reg("cnt1", TMR_COUNT, 32'd1);
        repeat (98) @(negedge aclk);
        rd_reg("cnt0", TMR_COUNT, 32'd0);
        rd_reg("st_before_exp", TMR_STATUS, 32'd0);
        repeat (60) @(negedge aclk);
        rd_reg("st_after_exp", TMR_STATUS, 32'd1);
        rd_reg("ctrl_after_exp", TMR_CTRL, 32'd0);

        // Error responses
        xfer(1'b1, TMR_COUNT, 32'h1234);
        chk("cnt_wr_slverr", 32'(x_se), 32'd1);
        chk("cnt_wr_decerr", 32'(x_de), 32'd0);
        chk("cnt_wr_done", 32'(x_wd), 32'd1);
        rd_reg("cnt_unchanged", TMR_COUNT, 32'd0);
        chk("cnt_rd_noerr", 32'(x_se), 32'd0);
        xfer(1'b0, 8'h20, 32'd0);
        chk("unmap_rd_dec", 32'(x_de), 32'd1);
        chk("unmap_rd_slv", 32'(x_se), 32'd0);
        chk("unmap_rd_data", x_rd, 32'd0);
        xfer(1'b1, 8'h20, 32'hFFFF_FFFF);
        chk("unmap_wr_dec", 32'(x_de), 32'd1);
        rd_reg("unmap_wr_noop", TMR_CTRL, 32'd0);

        // Auto-reload with irq: period 3 ticks x 4 cycles
        wr_reg(TMR_STATUS, 32'h1);
        wr_reg(TMR_PRESCALE, 32'd3);
        wr_reg(TMR_LOAD, 32'd2);
        wr_reg(TMR_CTRL, 32'h7);
        x0 = x_exec;
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (irq) begin
                t = cyc;
                break;
            end
        end
        chk("ar_first_exp", 32'(t - x0), 32'd12);
        e0 = t;
        while (cyc < e0 + 22) @(negedge aclk);
        wr_reg(TMR_STATUS, 32'h1);
        chk("w1c_coinc_cycle", 32'(x_exec - e0), 32'd24);
        chk("w1c_coinc_irq", 32'(irq), 32'd1);
        while (cyc < e0 + 39) @(negedge aclk);
        wr_reg(TMR_STATUS, 32'h1);
        chk("w1c_irq_low", 32'(irq), 32'd0);
        t = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (irq) begin
                t = cyc;
                break;
            end
        end
        chk("ar_period", 32'(t - e0), 32'd48);
        rd_reg("ar_status", TMR_STATUS, 32'd1);
        wr_reg(TMR_CTRL, 32'h3);
        chk("irq_en_off", 32'(irq), 32'd0);
        wr_reg(TMR_CTRL, 32'h0);

        // Handshake timing with a slow controller
        cs = 1'b1; rd = 1'b1; addr = TMR_LOAD;
        #1 chk("hs_sr_pulse", 32'({signal_received, idle}), 32'b11);
        @(negedge aclk);
        cs = 1'b0; rd = 1'b0;
        chk("hs_exec", 32'({signal_received, idle, rd_done}), 32'b000);
        @(negedge aclk);
        chk("hs_done_lat2", 32'(rd_done), 32'd1);
        held = 1'b1;
        repeat (5) begin
            @(negedge aclk);
            if (!rd_done || idle) held = 1'b0;
        end
        chk("hs_done_held", 32'(held), 32'd1);
        tc = 1'b1;
        @(negedge aclk);
        tc = 1'b0;
        chk("hs_idle_back", 32'({idle, rd_done}), 32'b10);
        chk("hs_rd_data_kept", rd_data, 32'd2);

        // Deselected strobes and stray completion pulses
        cs = 1'b0; rd = 1'b1; addr = TMR_CTRL;
        bad = 1'b0;
        repeat (5) begin
            @(negedge aclk);
            if (!idle || signal_received || rd_done) bad = 1'b1;
        end
        rd = 1'b0;
        chk("nosel_ignored", 32'(bad), 32'd0);
        tc = 1'b1;
        @(negedge aclk);
        tc = 1'b0;
        chk("tc_idle_ignored", 32'({idle, rd_done, wr_done}), 32'b100);
        cs = 1'b1; rd = 1'b1; addr = TMR_STATUS;
        @(negedge aclk);
        cs = 1'b0; rd = 1'b0; tc = 1'b1;
        @(negedge aclk);
        tc = 1'b0;
        @(negedge aclk);
        chk("tc_exec_ignored", 32'({rd_done, idle}), 32'b10);
        tc = 1'b1;
        @(negedge aclk);
        tc = 1'b0;
        chk("tc_exec_finish", 32'(idle), 32'd1);

        // Reset while holding a response
        cs = 1'b1; wr = 1'b1; addr = TMR_LOAD;
        @(negedge aclk);
        cs = 1'b0; wr = 1'b0; wdata = 32'd9;
        @(negedge aclk);
        chk("rst_in_resp", 32'(wr_done), 32'd1);
        arst_n = 1'b0;
        #1;
        chk("rst_abort_flags", 32'({wr_done, rd_done, idle, slave_error,
            decode_error, signal_received, irq}), 32'b0010000);
        chk("rst_abort_rd", rd_data, 32'd0);
        @(negedge aclk);
        arst_n = 1'b1;
        @(negedge aclk);
        rd_reg("rst_load_clr", TMR_LOAD, 32'd0);
        wr_reg(TMR_LOAD, 32'd7);
        chk("post_rst_wr", 32'(x_wd), 32'd1);
        rd_reg("post_rst_load", TMR_LOAD, 32'd7);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
